// File: rtl/jtframe_pocket_pkg.sv
// Shared types and constants for the Pocket download serialiser.
package jtframe_pocket_pkg;

    localparam logic [7:0] CMD_SPACE = 8'hF8;

    typedef enum logic [1:0] {IDLE, LOAD, WR, WAIT} state_t;

    function automatic int unsigned beats_per_word(input int unsigned dw);
        return 32 / dw;
    endfunction

endpackage

// File: rtl/jtframe_pocket_dwnld_if.sv
// Bridge-side write port and ioctl loader port of the Pocket download serialiser.
// JTFRAME_POCKET_CHKSUM_EN adds the chksum signal.
interface jtframe_pocket_dwnld_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 25
);
    logic          wr_s;
    logic [31:0]   addr_s;
    logic [31:0]   data_s;
    logic [15:0]   slot_id;
    logic          slot_done;
    logic          prog_rdy;
    logic [AW-1:0] ioctl_addr;
    logic [DW-1:0] ioctl_dout;
    logic          ioctl_wr;
    logic [7:0]    ioctl_index;
    logic          downloading;
    logic          busy;
    logic          ovf;
`ifdef JTFRAME_POCKET_CHKSUM_EN
    logic [15:0]   chksum;

    modport master (
        output wr_s, addr_s, data_s, slot_id, slot_done, prog_rdy,
        input  ioctl_addr, ioctl_dout, ioctl_wr, ioctl_index, downloading, busy, ovf, chksum
    );
    modport slave (
        input  wr_s, addr_s, data_s, slot_id, slot_done, prog_rdy,
        output ioctl_addr, ioctl_dout, ioctl_wr, ioctl_index, downloading, busy, ovf, chksum
    );
`else
    modport master (
        output wr_s, addr_s, data_s, slot_id, slot_done, prog_rdy,
        input  ioctl_addr, ioctl_dout, ioctl_wr, ioctl_index, downloading, busy, ovf
    );
    modport slave (
        input  wr_s, addr_s, data_s, slot_id, slot_done, prog_rdy,
        output ioctl_addr, ioctl_dout, ioctl_wr, ioctl_index, downloading, busy, ovf
    );
`endif
endinterface

// File: rtl/jtframe_pocket_wfifo.sv
// Single-clock word FIFO; a push into a full FIFO succeeds when a pop frees a slot in the same cycle.
module jtframe_pocket_wfifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WW    = 55
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [WW-1:0] din_i,
    output logic [WW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          drop_c_o,
    output logic          empty_nxt_c_o
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o        = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o       = (cnt_q == '0);
    assign do_pop        = pop_i && !empty_o;
    assign do_push       = push_i && (!full_o || do_pop);
    assign drop_c_o      = push_i && !do_push;
    assign cnt_d         = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    assign empty_nxt_c_o = (cnt_d == '0);
    assign dout_o        = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PW'(1);
            if (do_pop)  rptr_q <= rptr_q + PW'(1);
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/jtframe_pocket_dwnld.sv
// Buffers bridge data-slot writes and serialises them into DW-bit ioctl beats paced by prog_rdy.
// JTFRAME_POCKET_CHKSUM_EN adds a running 16-bit sum of emitted beats.
module jtframe_pocket_dwnld
    import jtframe_pocket_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 25,
    parameter int unsigned SWAP  = 0
) (
    input  logic clk,
    input  logic rst_n,
    jtframe_pocket_dwnld_if.slave bus
);
    localparam int unsigned BEATS = beats_per_word(DW);
    localparam int unsigned BCW   = $clog2(BEATS);
    localparam int unsigned BYTES = DW / 8;
    localparam int unsigned FW    = AW - 2 + 32;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    state_t         state_q, state_d;
    logic [BCW-1:0] beat_q, beat_d, sel;
    logic [FW-1:0]  word_q, word_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  dout_q, dout_d;
    logic [7:0]     index_q, index_d;
    logic           wr_q, wr_d;
    logic           dl_q, dl_d;
    logic           busy_q, busy_d;
    logic           ovf_q, ovf_d;
    logic           pend_q, pend_d;
    logic [31:0]    shifted;

    logic          accept, start, fifo_pop;
    logic [FW-1:0] fifo_din, fifo_dout;
    logic          fifo_full, fifo_empty, fifo_drop, fifo_empty_nxt;
    logic          unused_bits;

    assign accept      = bus.wr_s && (bus.addr_s[31:24] != CMD_SPACE);
    assign start       = accept && !dl_q;
    assign fifo_pop    = (state_q == LOAD);
    assign fifo_din    = {bus.addr_s[AW-1:2], bus.data_s};
    assign unused_bits = ^{bus.addr_s[1:0], bus.slot_id[15:8], fifo_full};

    jtframe_pocket_wfifo #(.DEPTH(DEPTH), .WW(FW)) u_wfifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .push_i        (accept),
        .pop_i         (fifo_pop),
        .din_i         (fifo_din),
        .dout_o        (fifo_dout),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty),
        .drop_c_o      (fifo_drop),
        .empty_nxt_c_o (fifo_empty_nxt)
    );

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        word_d  = word_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        index_d = index_q;
        dl_d    = dl_q;
        ovf_d   = ovf_q;
        pend_d  = pend_q;
        sel     = '0;
        shifted = '0;

        case (state_q)
            IDLE: if (!fifo_empty) state_d = LOAD;
            LOAD: begin
                word_d  = fifo_dout;
                beat_d  = '0;
                state_d = WR;
            end
            WR:   state_d = WAIT;
            WAIT: if (bus.prog_rdy) begin
                if (beat_q != LAST_BEAT) begin
                    beat_d  = beat_q + BCW'(1);
                    state_d = WR;
                end else if (!fifo_empty) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Beat address/data are loaded on entry to WR and held until the next WR.
        if (state_d == WR) begin
            sel     = (SWAP != 0) ? LAST_BEAT - beat_d : beat_d;
            shifted = word_d[31:0] >> (32'(sel) * DW);
            dout_d  = shifted[DW-1:0];
            addr_d  = {word_d[FW-1:32], 2'b00} + AW'(32'(beat_d) * BYTES);
        end

        if (start) begin
            dl_d    = 1'b1;
            index_d = bus.slot_id[7:0];
            ovf_d   = 1'b0;
            pend_d  = 1'b0;
        end
        if (fifo_drop) ovf_d = 1'b1;

        // A done with work outstanding is deferred until the queue and FSM drain.
        if (dl_q && bus.slot_done) begin
            if (busy_q || accept) pend_d = 1'b1;
            else                  dl_d   = 1'b0;
        end else if (pend_q && state_q == IDLE && fifo_empty && !accept) begin
            dl_d   = 1'b0;
            pend_d = 1'b0;
        end

        wr_d   = (state_d == WR);
        busy_d = !fifo_empty_nxt || (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            index_q <= '0;
            wr_q    <= 1'b0;
            dl_q    <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            index_q <= index_d;
            wr_q    <= wr_d;
            dl_q    <= dl_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.ioctl_addr  = addr_q;
    assign bus.ioctl_dout  = dout_q;
    assign bus.ioctl_wr    = wr_q;
    assign bus.ioctl_index = index_q;
    assign bus.downloading = dl_q;
    assign bus.busy        = busy_q;
    assign bus.ovf         = ovf_q;

`ifdef JTFRAME_POCKET_CHKSUM_EN
    logic [15:0] chksum_q, chksum_d;

    always_comb begin
        chksum_d = chksum_q;
        if (start)     chksum_d = '0;
        else if (wr_q) chksum_d = chksum_q + 16'(dout_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chksum_q <= '0;
        else        chksum_q <= chksum_d;
    end

    assign bus.chksum = chksum_q;
`endif

endmodule
